pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_CH, default 2, number of 32-bit data channels carried (e.g. ALU result, store data); range 1..8.
REQ-002 Parameter RD_W, default 5, destination-register field width.
REQ-003 Parameter T_W, default 2, width of Tuse/Tnew hazard counters.
REQ-004 Parameter PC_RST, default 32'h0000_3000, PC value held when empty, reset or flushed.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 flush  in  1  synchronous bubble insert; discards all held entries.
REQ-008 in_valid  in  1  upstream entry present.
REQ-009 in_ready  out  1  stage can accept an entry this cycle.
REQ-010 ins_i, pc_i  in  32 each  instruction word and PC.
REQ-011 data_i  in  32*DATA_CH  channel k at bits [32k+31:32k].
REQ-012 rd_i  in  RD_W; tuse_i, tnew_i  in  T_W each.
REQ-013 out_valid  out  1; out_ready  in  1  downstream handshake.
REQ-014 ins_o, pc_o, data_o, rd_o, tuse_o, tnew_o  out  same widths as inputs, registered.

Function
REQ-015 Transfer in occurs when in_valid && in_ready && !flush; transfer out when out_valid && out_ready.
REQ-016 Captured tuse/tnew = saturating decrement of input (value-1 if >0, else 0); all other fields copied unchanged.
REQ-017 Latency: entry accepted in cycle N appears on outputs in cycle N+1 when the stage was empty or draining.
REQ-018 Main entry (M) drives outputs; out_valid = M valid; when M empty, outputs hold reset values (ins 0, pc PC_RST, data 0, rd 0, tuse 0, tnew 0).
REQ-019 States: EMPTY (M invalid), ONE (M valid, skid invalid), FULL (M and skid valid).
REQ-020 EMPTY: transfer in -> ONE.
REQ-021 ONE: in+out -> ONE with M<=input; out only -> EMPTY; in only -> FULL with skid<=input; neither -> hold.
REQ-022 FULL: out -> ONE with M<=skid; in_ready=0 so no capture; no out -> hold.
REQ-023 in_ready is a register output: 1 in EMPTY and ONE, 0 in FULL; no combinational path from out_ready to in_ready.
REQ-024 Ordering strictly FIFO; no entry dropped or duplicated absent flush.
REQ-025 flush: next state EMPTY, all fields to reset values, in_valid ignored that cycle, in_ready=1 next cycle; flush beats any simultaneous transfer.
REQ-026 Held entries keep fields (incl. tnew) constant while stalled; no decrement without capture.

Reset
REQ-027 rst_n low asynchronously forces EMPTY, in_ready=1, out_valid=0, all output fields to REQ-018 values; skid cleared.
REQ-028 Stage first accepts input on the first rising edge with rst_n high; reset asserted mid-transfer discards both entries.

Configuration
REQ-029 Macro PIPE_STAGE_SKID_EN defined: two-entry skid behaviour of REQ-019..REQ-023.
REQ-030 Macro undefined: single entry, no FULL state, in_ready = !out_valid || out_ready (combinational); all other requirements unchanged.

Verification
REQ-031 Reset: rst_n=0 mid-cycle -> out_valid=0, pc_o=32'h3000, in_ready=1 immediately, without clock edge.
REQ-032 Streaming: in_valid=1, out_ready=1, ins_i=32'h8C01_0004, tnew_i=2 -> next cycle out_valid=1, ins_o=32'h8C01_0004, tnew_o=1; tnew_i=0 -> tnew_o=0.
REQ-033 Backpressure (SKID_EN): out_ready=0, push A (pc 3000) then B (pc 3004) -> in_ready=0 after B; release out_ready -> A then B on successive cycles, in_ready back to 1.
REQ-034 Flush in FULL with in_valid=1 (pc 3008) -> next cycle out_valid=0, pc_o=32'h3000, C not captured.
REQ-035 Stall hold: ONE with tnew_o=1, out_ready=0 for 5 cycles -> tnew_o stays 1, data_o unchanged.
REQ-036 Random valid/ready with DATA_CH=3, SKID_EN on and off -> scoreboard order matches, no loss, 1000 entries.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register carrying instruction, PC, data channels and hazard counters.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with registered in_ready.
module pipe_stage_reg #(
    parameter int          DATA_CH = 2,
    parameter int          RD_W    = 5,
    parameter int          T_W     = 2,
    parameter logic [31:0] PC_RST  = 32'h0000_3000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            ins_i,
    input  logic [31:0]            pc_i,
    input  logic [32*DATA_CH-1:0]  data_i,
    input  logic [RD_W-1:0]        rd_i,
    input  logic [T_W-1:0]         tuse_i,
    input  logic [T_W-1:0]         tnew_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            ins_o,
    output logic [31:0]            pc_o,
    output logic [32*DATA_CH-1:0]  data_o,
    output logic [RD_W-1:0]        rd_o,
    output logic [T_W-1:0]         tuse_o,
    output logic [T_W-1:0]         tnew_o,
    output logic [1:0]             dbg_state
);

    localparam int EW = 64 + 32*DATA_CH + RD_W + 2*T_W;
    localparam logic [EW-1:0] RST_ENTRY = {32'd0, PC_RST, {(EW-64){1'b0}}};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Handshake: a beat moves when valid and ready are both high at a rising
    // edge; flush overrides any simultaneous beat on the input side.

    function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] v);
        return (v == '0) ? '0 : v - T_W'(1);
    endfunction

    state_t          r_state;
    state_t          w_state_n;
    logic [EW-1:0]   r_main;
    logic [EW-1:0]   w_in_entry;
    logic            w_xfer_in;
    logic            w_xfer_out;
    logic            w_load_main_in;

    assign w_in_entry = {ins_i, pc_i, data_i, rd_i, sat_dec(tuse_i), sat_dec(tnew_i)};
    assign out_valid  = (r_state != ST_EMPTY);
    assign w_xfer_in  = in_valid && in_ready && !flush;
    assign w_xfer_out = out_valid && out_ready;
    assign dbg_state  = r_state;
    assign {ins_o, pc_o, data_o, rd_o, tuse_o, tnew_o} = r_main;

`ifdef PIPE_STAGE_SKID_EN
    logic            r_in_ready;
    logic [EW-1:0]   r_skid;
    logic            w_load_skid;
    logic            w_load_main_skid;

    assign in_ready = r_in_ready;
`else
    // Single entry: room exists if empty or the held entry leaves this cycle.
    assign in_ready = (r_state == ST_EMPTY) || out_ready;
`endif

    always_comb begin
        w_state_n      = r_state;
        w_load_main_in = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        w_load_skid      = 1'b0;
        w_load_main_skid = 1'b0;
`endif
        if (flush) begin
            w_state_n = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_xfer_in) begin
                        w_state_n      = ST_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_xfer_in && w_xfer_out) begin
                        w_load_main_in = 1'b1;
                    end else if (w_xfer_out) begin
                        w_state_n = ST_EMPTY;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (w_xfer_in) begin
                        w_state_n   = ST_FULL;
                        w_load_skid = 1'b1;
`endif
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                ST_FULL: begin
                    if (w_xfer_out) begin
                        w_state_n        = ST_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
`endif
                default: w_state_n = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_n;
        end
    end

    // An empty stage presents reset values, so clear the main entry on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= RST_ENTRY;
        end else if (w_state_n == ST_EMPTY) begin
            r_main <= RST_ENTRY;
        end else if (w_load_main_in) begin
            r_main <= w_in_entry;
`ifdef PIPE_STAGE_SKID_EN
        end else if (w_load_main_skid) begin
            r_main <= r_skid;
`endif
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid <= RST_ENTRY;
        end else if (flush || w_load_main_skid) begin
            r_skid <= RST_ENTRY;
        end else if (w_load_skid) begin
            r_skid <= w_in_entry;
        end
    end

    // Registered so out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= (w_state_n != ST_FULL);
        end
    end
`endif

endmodule
